// File: rtl/sliced_serial_adder.sv
// ---------------------------------------------------------------------------
// sliced_serial_adder
//
// Multi-cycle adder that sums two WIDTH-bit operands plus a carry-in,
// SLICE bits per clock, with the carry held in a register between slices.
// An optional lower-part-OR approximation covers the low APPROX_BITS bits.
// The approximation is chosen per operation with approx_en.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready is high only in IDLE. out_valid is
// high only in DONE. Neither depends combinationally on any input. Once
// out_valid is high, sum and cout stay stable until out_ready is seen.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand set valid
//   in_ready   ready to accept operands (state == IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry-in (ignored in approx mode when APPROX_BITS > 0)
//   approx_en  select approximate mode for this operation
//   out_valid  result valid (state == DONE)
//   out_ready  consumer accepts result
//   sum        WIDTH-bit result
//   cout       carry-out of bit WIDTH-1
// ---------------------------------------------------------------------------
module sliced_serial_adder #(
  parameter int WIDTH       = 16,
  parameter int SLICE       = 4,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Ones in the low APPROX_BITS positions: these bits are OR-approximated.
  localparam logic [WIDTH-1:0] LOW_MASK =
    (APPROX_BITS == 0) ? '0 : ({WIDTH{1'b1}} >> (WIDTH - APPROX_BITS));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // Operands and mask shift right by SLICE every RUN cycle. The slice being
  // processed therefore always sits in the low SLICE bits.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] mask_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic [SLICE-1:0] slice_sum;
  logic             slice_carry;
  logic [WIDTH-1:0] sum_next;

  // Ripple through one slice. An approximated bit ignores its incoming
  // carry. Its own carry-out is a&b. A run of approximated bits therefore
  // leaves exactly a[K-1]&b[K-1] as the carry into bit K. That carry is
  // correct even when the approximate region ends in the middle of a slice.
  always_comb begin
    logic c;
    c         = carry_q;
    slice_sum = '0;
    for (int j = 0; j < SLICE; j++) begin
      if (mask_q[j]) begin
        slice_sum[j] = a_q[j] | b_q[j];
        c            = a_q[j] & b_q[j];
      end else begin
        slice_sum[j] = a_q[j] ^ b_q[j] ^ c;
        c            = (a_q[j] & b_q[j]) | (c & (a_q[j] ^ b_q[j]));
      end
    end
    slice_carry = c;
  end

  // Each new slice enters at the top of the result register, and earlier
  // slices move down. After N slices, slice 0 sits in bits [SLICE-1:0].
  assign sum_next = WIDTH'({slice_sum, sum_q} >> SLICE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mask_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            mask_q  <= approx_en ? LOW_MASK : '0;
            carry_q <= cin;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_next;
          carry_q <= slice_carry;
          a_q     <= a_q >> SLICE;
          b_q     <= b_q >> SLICE;
          mask_q  <= mask_q >> SLICE;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            cout_q <= slice_carry;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_sliced_serial_adder.sv
module tb_sliced_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: {cout,sum} for a 16-bit operation, from the arithmetic rules.
  function automatic logic [16:0] ref_add(input logic [15:0] xa, input logic [15:0] xb,
                                          input logic xc, input logic ap, input int k);
    logic [16:0] lo;
    logic [16:0] hi;
    logic [15:0] m;
    logic        cr;
    if (!ap || k == 0) return {1'b0, xa} + {1'b0, xb} + 17'(xc);
    m  = (k >= 16) ? 16'hFFFF : ((16'h1 << k) - 16'h1);
    lo = {1'b0, (xa | xb) & m};
    cr = xa[k-1] & xb[k-1];
    if (k >= 16) return {cr, xa | xb};
    hi = ({1'b0, xa >> k} + {1'b0, xb >> k} + 17'(cr)) << k;
    return hi | lo;
  endfunction

  // ---------------- default-configuration DUT ----------------
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        approx_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;

  sliced_serial_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx_en(approx_en),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  // ---------------- WIDTH=8, SLICE=8, APPROX_BITS=8 DUT ----------------
  logic       p_rst = 1'b1;
  logic       p_in_valid = 1'b0;
  logic       p_in_ready;
  logic [7:0] p_a = '0;
  logic [7:0] p_b = '0;
  logic       p_cin = 1'b0;
  logic       p_approx_en = 1'b0;
  logic       p_out_valid;
  logic       p_out_ready = 1'b0;
  logic [7:0] p_sum;
  logic       p_cout;

  sliced_serial_adder #(.WIDTH(8), .SLICE(8), .APPROX_BITS(8)) dut_p (
    .clk(clk), .rst(p_rst), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .a(p_a), .b(p_b), .cin(p_cin), .approx_en(p_approx_en),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .sum(p_sum), .cout(p_cout)
  );

  // ---------------- driver tasks (default DUT) ----------------
  // Present operands, wait for the accept edge, then measure cycles to out_valid.
  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                        input logic xap, output int lat);
    int w;
    @(negedge clk);
    a = xa; b = xb; cin = xc; approx_en = xap; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); approx_en = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- randomized regression on several configurations ----------------
  localparam int NOPS = 2000;

  for (genvar g = 0; g < 6; g++) begin : g_rnd
    localparam int SL = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 16 : (g == 4) ? 1 : 16;
    localparam int KB = (g == 0) ? 5 : (g == 1) ? 0 : (g == 2) ? 16 : (g == 3) ? 5 : (g == 4) ? 16 : 0;

    logic        r_rst = 1'b1;
    logic        r_in_valid = 1'b0;
    logic        r_in_ready;
    logic [15:0] r_a = '0;
    logic [15:0] r_b = '0;
    logic        r_cin = 1'b0;
    logic        r_approx_en = 1'b0;
    logic        r_out_valid;
    logic        r_out_ready = 1'b0;
    logic [15:0] r_sum;
    logic        r_cout;
    bit          done = 1'b0;
    logic [16:0] exp_q[$];

    sliced_serial_adder #(.WIDTH(16), .SLICE(SL), .APPROX_BITS(KB)) dut_r (
      .clk(clk), .rst(r_rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
      .a(r_a), .b(r_b), .cin(r_cin), .approx_en(r_approx_en),
      .out_valid(r_out_valid), .out_ready(r_out_ready), .sum(r_sum), .cout(r_cout)
    );

    initial begin
      repeat (2) @(negedge clk);
      r_rst = 1'b0;
      fork
        begin : drv
          int w;
          for (int op = 0; op < NOPS; op++) begin
            repeat ($urandom_range(0, 2)) begin
              @(negedge clk);
              r_in_valid = 1'b0;
            end
            @(negedge clk);
            r_a = 16'($urandom); r_b = 16'($urandom);
            r_cin = 1'($urandom); r_approx_en = 1'($urandom);
            r_in_valid = 1'b1;
            w = 0;
            while (!r_in_ready && w < 200) begin
              @(negedge clk);
              w++;
            end
            if (!r_in_ready) begin
              check($sformatf("rnd%0d_accept_timeout", g), 32'(r_in_ready), 32'd1);
              break;
            end
            exp_q.push_back(ref_add(r_a, r_b, r_cin, r_approx_en, KB));
          end
          @(negedge clk);
          r_in_valid = 1'b0;
        end
        begin : mon
          int got;
          int cyc;
          logic [16:0] e;
          got = 0;
          cyc = 0;
          while (got < NOPS && cyc < 90000) begin
            @(negedge clk);
            cyc++;
            r_out_ready = ($urandom_range(0, 3) != 0);
            if (r_out_valid && r_out_ready) begin
              if (exp_q.size() == 0) begin
                check($sformatf("rnd%0d_spurious", g), 32'd1, 32'd0);
              end else begin
                e = exp_q.pop_front();
                check($sformatf("rnd%0d_result", g), 32'({r_cout, r_sum}), 32'(e));
              end
              got++;
            end
          end
          if (got < NOPS) check($sformatf("rnd%0d_result_count", g), 32'(got), 32'(NOPS));
          @(negedge clk);
          r_out_ready = 1'b0;
        end
      join
      check($sformatf("rnd%0d_leftover", g), 32'(exp_q.size()), 32'd0);
      done = 1'b1;
    end
  end

  // ---------------- directed tests + report ----------------
  initial begin
    int lat;
    int t;
    int acc[$];
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rap;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    p_rst = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);

    // Exact add with full carry ripple, latency N=4
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_sum", 32'(sum), 32'h0000);
    check("t1_cout", 32'(cout), 32'd1);
    take_result();

    // Exact with carry-in, then approximate mode
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, lat);
    check("t2_exact", 32'({cout, sum}), 32'h05556);
    take_result();
    run_op(16'h0008, 16'h0008, 1'b0, 1'b1, lat);
    check("t2_approx_carry", 32'({cout, sum}), 32'h00018);
    take_result();
    run_op(16'h000F, 16'h0001, 1'b1, 1'b1, lat);
    check("t2_approx_or", 32'({cout, sum}), 32'h0000F);
    take_result();

    // Backpressure with new operands waiting
    run_op(16'h00AA, 16'h0055, 1'b0, 1'b0, lat);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; approx_en = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_in_ready", 32'(in_ready), 32'd0);
      check("t3_hold_result", 32'({cout, sum}), 32'h000FF);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t3_idle_in_ready", 32'(in_ready), 32'd1);
    check("t3_idle_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("t3_new_accepted", 32'(in_ready), 32'd0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("t3_new_result", 32'({cout, sum}), 32'h03333);
    take_result();

    // Back-to-back throughput: accepts are N+2 = 6 cycles apart
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; approx_en = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (in_ready) acc.push_back(cyc);
      if (acc.size() == 2) break;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    out_ready = 1'b0;
    check("t3_accept_count", 32'(acc.size()), 32'd2);
    if (acc.size() == 2) check("t3_spacing", 32'(acc[1] - acc[0]), 32'd6);

    // Reset in the middle of RUN
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b1; approx_en = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_out_valid", 32'(out_valid), 32'd0);
    check("t4_sum", 32'(sum), 32'd0);
    check("t4_cout", 32'(cout), 32'd0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, lat);
    check("t4_latency", 32'(lat), 32'd4);
    check("t4_result", 32'({cout, sum}), 32'h10000);
    take_result();

    // Single-slice configuration, fully approximated
    @(negedge clk);
    p_a = 8'h81; p_b = 8'h81; p_cin = 1'b1; p_approx_en = 1'b1;
    p_in_valid = 1'b1;
    check("t5_in_ready", 32'(p_in_ready), 32'd1);
    @(posedge clk);
    #1;
    p_in_valid = 1'b0;
    check("t5_not_yet_valid", 32'(p_out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t5_out_valid", 32'(p_out_valid), 32'd1);
    check("t5_result", 32'({p_cout, p_sum}), 32'h181);
    @(negedge clk);
    p_out_ready = 1'b1;
    @(negedge clk);
    p_out_ready = 1'b0;
    check("t5_back_idle", 32'(p_in_ready), 32'd1);

    // Random operations on the default configuration
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rap = 1'($urandom);
      run_op(ra, rb, rc, rap, lat);
      check("dflt_latency", 32'(lat), 32'd4);
      check("dflt_result", 32'({cout, sum}), 32'(ref_add(ra, rb, rc, rap, 4)));
      take_result();
    end

    // Wait for the regression blocks
    t = 0;
    while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done &&
             g_rnd[3].done && g_rnd[4].done && g_rnd[5].done) && t < 95000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 95000) check("rnd_finish_timeout", 32'd0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
